// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO and its storage sub-module.
package fifo_pkg;

    // Default geometry: 8 entries of 8 bits, 3-bit pointers.
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_ADDR_WIDTH = 3;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// registered read port. The read register is the FIFO's data_out and
// holds its value whenever no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: written on accepted writes only, never reset
    // (stale entries are unreachable once the pointers are cleared).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read data: load the addressed entry on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : fifo_mem

// File: rtl/fifo.sv
// Synchronous single-clock FIFO. Pointers, occupancy count and the
// registered full/empty flags live here; storage is in fifo_mem.
// Note: rst_n is an active-high synchronous reset despite its name.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;

    logic wr_acc;
    logic rd_acc;

    // Accept a request only if it cannot overflow or underflow. Gating on
    // the registered flags makes read+write on an empty FIFO a pure write
    // and read+write on a full FIFO a pure read.
    always_comb begin
        wr_acc = write_enable & ~full_q;
        rd_acc = read_enable  & ~empty_q;
    end

    // Next pointers, count and flags; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign full  = full_q;
    assign empty = empty_q;

endmodule : fifo

// File: tb/tb_fifo.sv
// Bench for fifo: directed scenarios followed by random traffic, all
// checked against a queue-based reference model.
module tb_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_dout = '0;

    fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, compare all outputs after the edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        bit rok;
        bit wok;
        rst_n        = r;
        write_enable = w;
        read_enable  = rd;
        data_in      = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            rok = rd && (model_q.size() != 0);
            wok = w && (model_q.size() < DEPTH);
            if (rok) model_dout = model_q.pop_front();
            if (wok) model_q.push_back(d);
        end
        #1;
        chk("dout",  32'(data_out), 32'(model_dout));
        chk("full",  32'(full),  32'(model_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("excl",  32'(full & empty), 32'd0);
    endtask

    initial begin
        // Reset held two cycles
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h99);
        chk("rst_dout", 32'(data_out), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);

        // Order: 01,02,03, idle with data_in=04, write 04, read 4
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h02);
        step(0, 1, 0, 8'h03);
        step(0, 0, 0, 8'h04);
        step(0, 1, 0, 8'h04);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 8'h00);
            chk("order", 32'(data_out), 32'(i));
        end
        chk("order_empty", 32'(empty), 32'd1);

        // Underflow: data_out stays 04
        step(0, 0, 1, 8'h00);
        chk("underflow_dout", 32'(data_out), 32'h04);
        chk("underflow_empty", 32'(empty), 32'd1);

        // Fill with 10..17, drop 18, drain
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i));
        chk("full_set", 32'(full), 32'd1);
        step(0, 1, 0, 8'h18);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00);
            chk("drain", 32'(data_out), 32'(8'h10 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous with 2 entries
        step(0, 1, 0, 8'hA0);
        step(0, 1, 0, 8'hA1);
        step(0, 1, 1, 8'hA2);
        chk("simul_dout", 32'(data_out), 32'hA0);
        chk("simul_cnt", 32'(model_q.size()), 32'd2);
        // Fill, then read+write while full: only the read
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'hB0 + i));
        chk("simul_full", 32'(full), 32'd1);
        step(0, 1, 1, 8'hEE);
        chk("full_rw_dout", 32'(data_out), 32'hA1);
        chk("full_rw_full", 32'(full), 32'd0);
        // Drain, then read+write while empty: only the write
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h77);
        chk("empty_rw_empty", 32'(empty), 32'd0);
        chk("empty_rw_dout", 32'(data_out), 32'hB5);
        step(0, 0, 1, 8'h00);
        chk("empty_rw_read", 32'(data_out), 32'h77);

        // Mid-operation reset with 3 entries
        step(0, 1, 0, 8'h31);
        step(0, 1, 0, 8'h32);
        step(0, 1, 0, 8'h33);
        step(1, 1, 1, 8'h34);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_dout", 32'(data_out), 32'h00);
        step(0, 1, 0, 8'h55);
        step(0, 0, 1, 8'h00);
        chk("midrst_read", 32'(data_out), 32'h55);

        // Random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, bits per entry; DEPTH, 8, number of entries (power of two); ADDR_WIDTH, 3, log2(DEPTH).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-high reset; asserted when 1, despite the port name.
REQ-005 data_in  input  DATA_WIDTH  write data, sampled with write_enable.
REQ-006 write_enable  input  1  write request.
REQ-007 read_enable  input  1  read request.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when the FIFO holds DEPTH entries.
REQ-010 empty  output  1  high when the FIFO holds 0 entries.

Function
REQ-011 Ordering SHALL be first-in first-out, with no reordering and no data loss on accepted writes.
REQ-012 A write SHALL be accepted on a rising edge when write_enable=1 and full=0; data_in is stored at the write pointer, which then increments.
REQ-013 A read SHALL be accepted on a rising edge when read_enable=1 and empty=0; the entry at the read pointer is loaded into data_out on that edge (1-cycle latency), and the pointer increments.
REQ-014 data_out SHALL hold its last value when no read is accepted.
REQ-015 A write while full SHALL be ignored; storage, pointers and flags are unchanged.
REQ-016 A read while empty SHALL be ignored; data_out, pointers and flags are unchanged.
REQ-017 Simultaneous accepted read and write SHALL both occur with occupancy unchanged.
REQ-018 When empty, simultaneous read and write SHALL perform only the write; data_out is unchanged.
REQ-019 When full, simultaneous read and write SHALL perform only the read.
REQ-020 Pointers SHALL be ADDR_WIDTH bits wide and wrap modulo DEPTH.
REQ-021 Occupancy SHALL be tracked by an ADDR_WIDTH+1-bit count in the range 0..DEPTH.
REQ-022 full and empty SHALL be registered, updated on the same edge as count, and derived as full=(count==DEPTH), empty=(count==0).
REQ-023 full and empty SHALL never be high at the same time.

Reset
REQ-024 While rst_n=1 at a rising edge, the block SHALL set both pointers=0, count=0, data_out=0, empty=1 and full=0.
REQ-025 Reset SHALL take priority over simultaneous read or write requests; in-flight contents are discarded.
REQ-026 Storage array contents SHALL NOT require reset; stale data is unreachable once the pointers are cleared.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the default DATA_WIDTH, DEPTH and ADDR_WIDTH constants.
REQ-028 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DATA_WIDTH array with synchronous write port and synchronous read port.
REQ-029 Pointer, count, flag and control logic SHALL reside in fifo.

Verification
REQ-030 Reset: hold rst_n=1 for 2 cycles -> data_out=00, empty=1, full=0.
REQ-031 Write/read order: write 01,02,03; idle 1 cycle with data_in=04 and write_enable=0; write 04; read 4 times -> data_out=01,02,03,04 on successive edges, empty=1 after the 4th read.
REQ-032 Full: write 8 values 10..17 -> full=1 after the 8th; a 9th write of 18 is dropped; reading 8 -> 10..17 in order, then empty=1.
REQ-033 Underflow: read while empty with data_out=04 -> data_out stays 04, empty stays 1, count stays 0.
REQ-034 Simultaneous: with 2 entries (A0,A1), read+write A2 -> data_out=A0, count=2; when full, read+write -> only the read occurs; when empty, read+write -> only the write, empty deasserts.
REQ-035 Mid-operation reset: with 3 entries stored, assert reset 1 cycle -> empty=1, data_out=00; next write 55 then read -> data_out=55.
